// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths and constants for the operand fetch stage
package operand_fetch_pkg;
    localparam int REGBUS     = 32;
    localparam int REGADDRBUS = 5;
    localparam logic [REGBUS-1:0]     ZEROWORD     = '0;
    localparam logic [REGADDRBUS-1:0] ZERO_REG     = '0;
    localparam logic                  READ_ENABLE  = 1'b1;
    localparam logic                  WRITE_ENABLE = 1'b1;
endpackage

// File: rtl/operand_fetch_fwd_sel.sv
// operand_fetch_fwd_sel: per-operand source select; EX beats MEM beats regfile, loads in EX raise a hazard
module operand_fetch_fwd_sel
    import operand_fetch_pkg::*;
#(
    parameter int DW = REGBUS,
    parameter int AW = REGADDRBUS
) (
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    input  logic [DW-1:0] i_rf_rdata,
    input  logic          i_ex_we,
    input  logic [AW-1:0] i_ex_waddr,
    input  logic [DW-1:0] i_ex_wdata,
    input  logic          i_ex_is_load,
    input  logic          i_mem_we,
    input  logic [AW-1:0] i_mem_waddr,
    input  logic [DW-1:0] i_mem_wdata,
    output logic [DW-1:0] o_data,
    output logic          o_hazard
);
    logic w_live, w_ex_hit, w_mem_hit;

    assign w_live    = i_re == READ_ENABLE && i_raddr != AW'(ZERO_REG);
    assign w_ex_hit  = w_live && i_ex_we == WRITE_ENABLE && i_ex_waddr == i_raddr;
    assign w_mem_hit = w_live && i_mem_we == WRITE_ENABLE && i_mem_waddr == i_raddr;

    always_comb begin
        o_hazard = w_ex_hit && i_ex_is_load;
        o_data   = !w_live   ? DW'(ZEROWORD) :
                   w_ex_hit  ? (i_ex_is_load ? DW'(ZEROWORD) : i_ex_wdata) :
                   w_mem_hit ? i_mem_wdata : i_rf_rdata;
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: drives regfile reads, resolves forwarding/load-use stalls, and registers
// the operand pair into the ID/EX boundary with a valid/ready handshake.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DW = REGBUS,
    parameter int AW = REGADDRBUS,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic          id_re1,
    input  logic          id_re2,
    input  logic [AW-1:0] id_raddr1,
    input  logic [AW-1:0] id_raddr2,
    output logic          rf_re1,
    output logic          rf_re2,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_is_load,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    output logic [CW-1:0] stall_cnt
);
    logic          r_valid;
    logic [DW-1:0] r_opa, r_opb;
    logic [CW-1:0] r_stall_cnt;
    logic [DW-1:0] w_sel1, w_sel2;
    logic          w_haz1, w_haz2, w_hazard, w_accept;

    assign rf_re1    = id_valid && id_re1;
    assign rf_re2    = id_valid && id_re2;
    assign rf_raddr1 = id_raddr1;
    assign rf_raddr2 = id_raddr2;

    operand_fetch_fwd_sel #(.DW(DW), .AW(AW)) u_sel1 (
        .i_re(id_re1), .i_raddr(id_raddr1), .i_rf_rdata(rf_rdata1),
        .i_ex_we(ex_we), .i_ex_waddr(ex_waddr), .i_ex_wdata(ex_wdata), .i_ex_is_load(ex_is_load),
        .i_mem_we(mem_we), .i_mem_waddr(mem_waddr), .i_mem_wdata(mem_wdata),
        .o_data(w_sel1), .o_hazard(w_haz1)
    );

    operand_fetch_fwd_sel #(.DW(DW), .AW(AW)) u_sel2 (
        .i_re(id_re2), .i_raddr(id_raddr2), .i_rf_rdata(rf_rdata2),
        .i_ex_we(ex_we), .i_ex_waddr(ex_waddr), .i_ex_wdata(ex_wdata), .i_ex_is_load(ex_is_load),
        .i_mem_we(mem_we), .i_mem_waddr(mem_waddr), .i_mem_wdata(mem_wdata),
        .o_data(w_sel2), .o_hazard(w_haz2)
    );

    assign w_hazard = id_valid && (w_haz1 || w_haz2);
    assign id_ready = !rst && !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_opa   <= w_sel1;
                r_opb   <= w_sel2;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // saturate rather than wrap so long stalls never read as short ones
            if (w_hazard && !flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign opa       = r_opa;
    assign opb       = r_opb;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready, id_re1, id_re2;
    logic [4:0]  id_raddr1, id_raddr2, rf_raddr1, rf_raddr2, ex_waddr, mem_waddr;
    logic        rf_re1, rf_re2, ex_we, ex_is_load, mem_we, out_valid, out_ready;
    logic [31:0] rf_rdata1, rf_rdata2, ex_wdata, mem_wdata, opa, opb;
    logic [15:0] stall_cnt;
    logic [31:0] regs [32];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_re1(id_re1), .id_re2(id_re2), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .opa(opa), .opb(opb), .stall_cnt(stall_cnt)
    );

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got opa=%h opb=%h, expected no output", opa, opb);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({opa, opb} !== e) begin
                    n_fail++;
                    $display("FAIL sb_operands: got opa=%h opb=%h, expected opa=%h opb=%h", opa, opb, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; id_valid = 0; id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0; out_ready = 1;
    endtask

    task automatic req(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2);
        id_valid = 1; id_raddr1 = a1; id_raddr2 = a2; id_re1 = e1; id_re2 = e2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        req(3, 4, 1, 1);
        tick();
        tick();
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (opa !== 32'h0) begin n_fail++; $display("FAIL reset_opa: got %h expected 0", opa); end
        if (opb !== 32'h0) begin n_fail++; $display("FAIL reset_opb: got %h expected 0", opb); end
        if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", id_ready); end
        rst = 0;
        idle();
        tick();
    endtask

    task automatic test_plain_read();
        req(3, 4, 1, 1);
        exp_q.push_back({32'h11, 32'h22});
        #1;
        n_checks += 3;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL plain_ready: got %b expected 1", id_ready); end
        if ({rf_re1, rf_re2} !== 2'b11) begin n_fail++; $display("FAIL plain_rf_re: got %b expected 11", {rf_re1, rf_re2}); end
        if ({rf_raddr1, rf_raddr2} !== {5'd3, 5'd4}) begin n_fail++; $display("FAIL plain_rf_raddr: got %0d/%0d expected 3/4", rf_raddr1, rf_raddr2); end
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL plain_valid: got %b expected 1", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL plain_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_forward();
        req(5, 0, 1, 0);
        ex_we = 1; ex_waddr = 5; ex_wdata = 32'hAAAA;
        mem_we = 1; mem_waddr = 5; mem_wdata = 32'hBBBB;
        exp_q.push_back({32'hAAAA, 32'h0});
        tick();
        ex_we = 0;
        exp_q.push_back({32'hBBBB, 32'h0});
        tick();
        id_raddr1 = 0;
        exp_q.push_back({32'h0, 32'h0});
        tick();
        req(5, 5, 1, 1);
        ex_we = 1;
        exp_q.push_back({32'hAAAA, 32'hAAAA});
        tick();
        idle();
        tick();
    endtask

    task automatic test_load_use();
        req(3, 7, 1, 1);
        ex_we = 1; ex_is_load = 1; ex_waddr = 7; ex_wdata = 32'hDEAD;
        #1;
        n_checks += 2;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL lu_stall_start: got %0d expected 0", stall_cnt); end
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready0: got %b expected 0", id_ready); end
        tick();
        n_checks += 2;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready1: got %b expected 0", id_ready); end
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall1: got %0d expected 1", stall_cnt); end
        tick();
        n_checks++;
        if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_stall2: got %0d expected 2", stall_cnt); end
        ex_we = 0; ex_is_load = 0;
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'h55;
        exp_q.push_back({32'h11, 32'h55});
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b expected 1", id_ready); end
        tick();
        idle();
        tick();
        n_checks++;
        if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_stall_hold: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_backpressure();
        req(3, 4, 1, 1);
        exp_q.push_back({32'h11, 32'h22});
        tick();
        out_ready = 0;
        req(4, 3, 1, 1);
        exp_q.push_back({32'h22, 32'h11});
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, id_ready); end
            tick();
            n_checks++;
            if ({out_valid, opa, opb} !== {1'b1, 32'h11, 32'h22})
                begin n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b %h/%h expected v=1 11/22", i, out_valid, opa, opb); end
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", id_ready); end
        tick();
        idle();
        n_checks++;
        if ({out_valid, opa, opb} !== {1'b1, 32'h22, 32'h11})
            begin n_fail++; $display("FAIL bp_next: got v=%b %h/%h expected v=1 22/11", out_valid, opa, opb); end
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] sc;
        req(3, 3, 1, 1);
        exp_q.push_back({32'h11, 32'h11});
        tick();
        out_ready = 0;
        flush = 1;
        req(4, 4, 1, 1);
        ex_we = 1; ex_is_load = 1; ex_waddr = 4;
        sc = stall_cnt;
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", id_ready); end
        tick();
        void'(exp_q.pop_front());
        idle();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        if (stall_cnt !== sc) begin n_fail++; $display("FAIL flush_stall: got %0d expected %0d", stall_cnt, sc); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_capture: got %b expected 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[3] = 32'h11; regs[4] = 32'h22; regs[5] = 32'h5555; regs[7] = 32'h77;
        regs[0] = 32'hFFFF_FFFF;
        test_reset();
        test_plain_read();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
